// File: rtl/out_change_logger.sv
// Change logger: samples DIN on enabled edges, logs {gap, value} on each change
// into a first-word-fall-through FIFO with sticky overflow and saturating drop count.
module out_change_logger #(
  parameter int DW    = 8,
  parameter int GW    = 8,
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             CLK,
  input  logic             RSTX,
  input  logic [DW-1:0]    DIN,
  input  logic             EN,
  input  logic             CLR,
  output logic [GW+DW-1:0] DOUT,
  output logic             DVALID,
  input  logic             DREADY,
  output logic [AW:0]      LEVEL,
  output logic             OVF,
  output logic [7:0]       DROPS
);

  localparam logic [GW-1:0] GAP_MAX  = '1;
  localparam logic [AW:0]   LVL_FULL = (AW+1)'(DEPTH);

  logic [GW+DW-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [AW:0]      level;
  logic [DW-1:0]    din_q;
  logic [GW-1:0]    gap_cnt;
  logic             first;
  logic             ovf;
  logic [7:0]       drops;

  logic             sample;
  logic             event_hit;
  logic [GW-1:0]    gap_val;
  logic             full;
  logic             pop;
  logic             push;
  logic             drop;

  always_comb begin
    sample    = EN & ~CLR;
    event_hit = sample & (first | (DIN != din_q));
    gap_val   = first ? '0 : gap_cnt;
    full      = (level == LVL_FULL);
    pop       = ~CLR & (level != '0) & DREADY;
    // A full FIFO still accepts an event when the head leaves on the same edge.
    push      = event_hit & (~full | pop);
    drop      = event_hit & full & ~pop;
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {gap_val, DIN};
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else if (CLR) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   level <= level + 1'b1;
        2'b01:   level <= level - 1'b1;
        default: level <= level;
      endcase
    end
  end

  // Sampler state: din_q survives CLR so only first forces the post-clear event.
  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      din_q   <= '0;
      gap_cnt <= '0;
      first   <= 1'b1;
    end else if (CLR) begin
      gap_cnt <= '0;
      first   <= 1'b1;
    end else if (sample) begin
      din_q <= DIN;
      first <= 1'b0;
      if (event_hit)             gap_cnt <= GW'(1);
      else if (gap_cnt != GAP_MAX) gap_cnt <= gap_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RSTX) begin
    if (!RSTX) begin
      ovf   <= 1'b0;
      drops <= '0;
    end else if (CLR) begin
      ovf   <= 1'b0;
      drops <= '0;
    end else if (drop) begin
      ovf <= 1'b1;
      if (drops != 8'hFF) drops <= drops + 1'b1;
    end
  end

  assign DVALID = (level != '0);
  assign LEVEL  = level;
  assign DOUT   = DVALID ? mem[rd_ptr] : '0;
  assign OVF    = ovf;
  assign DROPS  = drops;

endmodule
